// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand/result bundle for the sequential magnitude comparator.
interface seq_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (output start, A, B, input busy, done, eq, gt, lt);
  modport slave  (input start, A, B, output busy, done, eq, gt, lt);
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Unsigned WIDTH-bit magnitude comparator that reuses one cascadable byte
// stage, streaming MSB byte first with the cascade state fed back each cycle.
module comparator_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       eqp,
  input  logic       gtp,
  output logic       eq,
  output logic       gt
);
  assign eq = eqp & (A == B);
  assign gt = gtp | (eqp & (A > B));
endmodule

module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  seq_magnitude_comparator_if.slave   bus
);
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CNT_W  = (NBYTES + 1 > 1) ? $clog2(NBYTES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             eq_acc;
  logic             gt_acc;
  logic [CNT_W-1:0] cnt;
  logic             eq_n;
  logic             gt_n;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  comparator_8bit u_stage (
    .A   (sa[WIDTH-1 -: 8]),
    .B   (sb[WIDTH-1 -: 8]),
    .eqp (eq_acc),
    .gtp (gt_acc),
    .eq  (eq_n),
    .gt  (gt_n)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; start only counts in IDLE or DONE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand shifters, cascade state, byte counter and result
  always_ff @(posedge clock) begin
    if (reset) begin
      sa     <= '0;
      sb     <= '0;
      eq_acc <= 1'b1;
      gt_acc <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      if (accept) begin
        sa     <= bus.A;
        sb     <= bus.B;
        eq_acc <= 1'b1;
        gt_acc <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        sa     <= sa << 8;
        sb     <= sb << 8;
        eq_acc <= eq_n;
        gt_acc <= gt_n;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          eq_q <= eq_n;
          gt_q <= gt_n;
          lt_q <= ~eq_n & ~gt_n;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: stimulus pushes expected
// results and timing, a negedge monitor checks every output every cycle.
module tb_seq_magnitude_comparator;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NBYTES = WIDTH / 8;

  typedef struct {
    logic [2:0] res;   // {eq, gt, lt}
    int         acc;   // edge index where start is accepted
    int         dcyc;  // edge index after which done is high
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [2:0] last_res = 3'b000;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: plain unsigned arithmetic on the whole operands
  function automatic logic [2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {a == b, a > b, a < b};
  endfunction

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic exp_busy;
    logic exp_done;
    if (reset) begin
      q.delete();
      last_res = 3'b000;
    end else begin
      exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dcyc);
      exp_done = (q.size() > 0) && (cyc == q[0].dcyc);
      n_cmp++;
      if (bus.busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, bus.busy, exp_busy);
      end
      n_cmp++;
      if (bus.done !== exp_done) begin
        n_fail++;
        $display("FAIL done cyc=%0d actual=%b required=%b", cyc, bus.done, exp_done);
      end
      if (exp_done) begin
        last_res = q[0].res;
        void'(q.pop_front());
      end
      n_cmp++;
      if ({bus.eq, bus.gt, bus.lt} !== last_res) begin
        n_fail++;
        $display("FAIL result cyc=%0d actual eq/gt/lt=%b required=%b",
                 cyc, {bus.eq, bus.gt, bus.lt}, last_res);
      end
    end
  end

  // Drive at posedge+1: accept happens at the following edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      step();
    end
    q.delete();  // a stuck entry has already been reported by the monitor
    step();
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    e.res  = model(a, b);
    e.acc  = cyc + 1;
    e.dcyc = cyc + 1 + int'(NBYTES);
    q.push_back(e);
    step();
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < int'(NBYTES); i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Directed cases
    issue(32'h1234_5678, 32'h1234_5678); drain(); step();
    issue(32'h8000_0000, 32'h7FFF_FFFF); drain();
    issue(32'h1234_5677, 32'h1234_5678); drain();
    issue(32'h1234_5678, 32'h1234_5677); drain();
    issue(32'h0000_0000, 32'hFFFF_FFFF); drain();

    // Start pulse and operand changes during RUN are ignored
    issue(32'h0000_0001, 32'h0000_0002);
    step();
    bus.start = 1'b1;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'hFFFF_FFFF;
    step();
    bus.start = 1'b0;
    drain();

    // Reset at the second busy cycle aborts the compare
    issue(32'hDEAD_BEEF, 32'h0000_0001);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();
    issue(32'h0000_0005, 32'h0000_0009); drain();

    // Back-to-back with start held high: one accept every NBYTES+1 edges
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      a = rand_op();
      b = (i % 3 == 0) ? a : rand_op();
      if (i == 4) b = a ^ WIDTH'(1);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      e.res  = model(a, b);
      e.acc  = cyc + 1;
      e.dcyc = cyc + 1 + int'(NBYTES);
      q.push_back(e);
      step();
      bus.A = WIDTH'($urandom);
      bus.B = WIDTH'($urandom);
      if (i < 5) repeat (NBYTES) step();
    end
    bus.start = 1'b0;
    drain();

    // Randomized single compares: random, equal, single-byte differences
    for (int i = 0; i < 40; i++) begin
      a = rand_op();
      case (i % 4)
        0: b = rand_op();
        1: b = a;
        default: begin
          b = a;
          b[8*($urandom_range(int'(NBYTES) - 1)) +: 8] = 8'($urandom);
        end
      endcase
      issue(a, b);
      drain();
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "time limit");
  end
endmodule
